fetch_pc_gen: RTL and testbench

Parametrised fetch-address generator at the head of the front end. It produces one aligned fetch-group PC per cycle, covering FETCH_WIDTH 32-bit instructions, plus a slot-valid mask and an epoch tag. Priority order is reset, redirect, stall, predicted jump, sequential. A redirect that arrives during a stall is buffered and applied when the stall releases, rather than being lost or blocked.

---
 rtl/fetch_pc_gen.sv | 175 +++++++++++++++++
 tb/tb_fetch_pc_gen.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/fetch_pc_gen.sv
// fetch_pc_gen: fetch-group PC generator for the head of the front end.
// Emits one fetch PC per cycle, along with a slot-valid mask and a redirect epoch.
// Priority order: reset, redirect, stall, predicted jump, sequential.
// A redirect that arrives while fetch is stalled is parked in PEND.
// It is then applied when the stall releases.
// Optional feature macro: FETCH_PC_ALIGN_CHK_EN. When defined, it flags loaded
// targets that are not 4-byte aligned.
module fetch_pc_gen #(
    parameter int                      PC_WIDTH    = 32,
    parameter int                      FETCH_WIDTH = 2,
    parameter logic [PC_WIDTH-1:0]     RESET_PC    = 32'h8000_0000,
    parameter int                      EPOCH_WIDTH = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_stall,
    input  logic                       i_redirect,
    input  logic [PC_WIDTH-1:0]        i_redirect_pc,
    input  logic                       i_pred_jmp,
    input  logic [PC_WIDTH-1:0]        i_pred_jmpaddr,
    output logic [PC_WIDTH-1:0]        o_pc,
    output logic                       o_valid,
    output logic [FETCH_WIDTH-1:0]     o_slot_mask,
    output logic [EPOCH_WIDTH-1:0]     o_epoch,
    output logic                       o_redirect_pending,
    output logic                       o_misalign
);

    localparam int                  GB       = 4 * FETCH_WIDTH;
    localparam int                  OFS      = $clog2(GB);
    localparam logic [PC_WIDTH-1:0] GB_BYTES = PC_WIDTH'(GB);
    localparam logic [PC_WIDTH-1:0] GB_MASK  = ~(GB_BYTES - PC_WIDTH'(1));
    localparam logic [PC_WIDTH-1:0] WORD_MSK = ~PC_WIDTH'(3);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [PC_WIDTH-1:0]    pc_q, pc_d;
    logic [PC_WIDTH-1:0]    pend_pc_q, pend_pc_d;
    logic [EPOCH_WIDTH-1:0] epoch_q, epoch_d;
    logic [PC_WIDTH-1:0]    seq_pc;
    logic [PC_WIDTH-1:0]    tgt;
    logic                   load_tgt;

`ifdef FETCH_PC_ALIGN_CHK_EN
    logic                   misalign_q, misalign_d;
`endif

    // The next group boundary wraps naturally modulo 2^PC_WIDTH.
    assign seq_pc = (pc_q & GB_MASK) + GB_BYTES;

    // Next-state logic. Any redirect, pending or predicted target is funnelled
    // through tgt/load_tgt so that its low bits are cleared in one place.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        pend_pc_d = pend_pc_q;
        epoch_d   = epoch_q;
        tgt       = pc_q;
        load_tgt  = 1'b0;

        unique case (state_q)
            BOOT: begin
                state_d = RUN;
                if (i_redirect) begin
                    tgt      = i_redirect_pc;
                    load_tgt = 1'b1;
                    epoch_d  = epoch_q + EPOCH_WIDTH'(1);
                end
            end
            RUN: begin
                if (i_redirect && !i_stall) begin
                    tgt      = i_redirect_pc;
                    load_tgt = 1'b1;
                    epoch_d  = epoch_q + EPOCH_WIDTH'(1);
                end else if (i_redirect) begin
                    pend_pc_d = i_redirect_pc;
                    epoch_d   = epoch_q + EPOCH_WIDTH'(1);
                    state_d   = PEND;
                end else if (i_stall) begin
                    pc_d = pc_q;
                end else if (i_pred_jmp) begin
                    tgt      = i_pred_jmpaddr;
                    load_tgt = 1'b1;
                end else begin
                    pc_d = seq_pc;
                end
            end
            PEND: begin
                if (i_redirect) begin
                    pend_pc_d = i_redirect_pc;
                    epoch_d   = epoch_q + EPOCH_WIDTH'(1);
                end
                if (!i_stall) begin
                    tgt      = i_redirect ? i_redirect_pc : pend_pc_q;
                    load_tgt = 1'b1;
                    state_d  = RUN;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase

        if (load_tgt) begin
            pc_d = tgt & WORD_MSK;
        end
    end

`ifdef FETCH_PC_ALIGN_CHK_EN
    // Raise a one-cycle flag alongside the PC update whenever the loaded target had its low bits set.
    always_comb begin
        misalign_d = load_tgt && (tgt[1:0] != 2'b00);
    end
`endif

    // State and PC registers. Reset is synchronous and active-low, and it wins from any state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= BOOT;
            pc_q      <= RESET_PC;
            pend_pc_q <= '0;
            epoch_q   <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pend_pc_q <= pend_pc_d;
            epoch_q   <= epoch_d;
        end
    end

`ifdef FETCH_PC_ALIGN_CHK_EN
    // Register the misalignment pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end

    assign o_misalign = misalign_q;
`else
    assign o_misalign = 1'b0;
`endif

    assign o_pc               = pc_q;
    assign o_valid            = (state_q == RUN);
    assign o_epoch            = epoch_q;
    assign o_redirect_pending = (state_q == PEND);

    generate
        if (FETCH_WIDTH == 1) begin : g_single_slot
            assign o_slot_mask = o_valid;
        end else begin : g_multi_slot
            localparam int IDX_W = OFS - 2;
            logic [IDX_W-1:0] slot_idx;

            assign slot_idx = pc_q[OFS-1:2];

            // Slots at or after the entry offset are live. The mask is zero when nothing is being fetched.
            always_comb begin
                o_slot_mask = '0;
                for (int i = 0; i < FETCH_WIDTH; i++) begin
                    o_slot_mask[i] = o_valid && (IDX_W'(i) >= slot_idx);
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_fetch_pc_gen.sv
// tb_fetch_pc_gen: directed scoreboard bench for fetch_pc_gen (default parameters).
// The driver pushes the hand-computed post-edge response for each vector.
// The monitor pops that response and compares it after every rising edge.
module tb_fetch_pc_gen;

    logic        clk;
    logic        rst_n;
    logic        i_stall;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;
    logic        i_pred_jmp;
    logic [31:0] i_pred_jmpaddr;
    logic [31:0] o_pc;
    logic        o_valid;
    logic [1:0]  o_slot_mask;
    logic [2:0]  o_epoch;
    logic        o_redirect_pending;
    logic        o_misalign;

`ifdef FETCH_PC_ALIGN_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] pc;
        logic        valid;
        logic [1:0]  mask;
        logic [2:0]  epoch;
        logic        pend;
        logic        mis;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    vectors;
    int    miscompares;
    bit    done;

    fetch_pc_gen dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .i_stall            (i_stall),
        .i_redirect         (i_redirect),
        .i_redirect_pc      (i_redirect_pc),
        .i_pred_jmp         (i_pred_jmp),
        .i_pred_jmpaddr     (i_pred_jmpaddr),
        .o_pc               (o_pc),
        .o_valid            (o_valid),
        .o_slot_mask        (o_slot_mask),
        .o_epoch            (o_epoch),
        .o_redirect_pending (o_redirect_pending),
        .o_misalign         (o_misalign)
    );

    // Free-running clock with a 10-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one vector on the falling edge and queue its expected post-edge response.
    task automatic applyStimulus(input string nm, input logic rst, input logic stall,
                                 input logic redir, input logic [31:0] rpc,
                                 input logic pj, input logic [31:0] jaddr,
                                 input logic [31:0] epc, input logic ev, input logic [1:0] em,
                                 input logic [2:0] ee, input logic ep, input logic emis);
        exp_t e;
        @(negedge clk);
        rst_n          = rst;
        i_stall        = stall;
        i_redirect     = redir;
        i_redirect_pc  = rpc;
        i_pred_jmp     = pj;
        i_pred_jmpaddr = jaddr;
        e.pc    = epc;
        e.valid = ev;
        e.mask  = em;
        e.epoch = ee;
        e.pend  = ep;
        e.mis   = emis & CHK;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Compare the DUT outputs with one expected entry.
    task automatic checkOutput(input string nm, input exp_t e);
        exp_t a;
        a = '{pc: o_pc, valid: o_valid, mask: o_slot_mask, epoch: o_epoch,
              pend: o_redirect_pending, mis: o_misalign};
        vectors++;
        if (a !== e) begin
            miscompares++;
            $display("[TB] FAIL %s: got pc=%h v=%b m=%b ep=%0d pend=%b mis=%b, want pc=%h v=%b m=%b ep=%0d pend=%b mis=%b",
                     nm, a.pc, a.valid, a.mask, a.epoch, a.pend, a.mis,
                     e.pc, e.valid, e.mask, e.epoch, e.pend, e.mis);
        end
    endtask

    // Monitor: sample just after each rising edge and retire one scoreboard entry.
    always begin
        exp_t  e;
        string nm;
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            checkOutput(nm, e);
        end
    end

    // Directed vectors. Columns: rst stall redir rpc pj jaddr | pc v mask epoch pend mis.
    initial begin
        vectors     = 0;
        miscompares = 0;
        done        = 1'b0;
        rst_n = 1'b0; i_stall = 1'b0; i_redirect = 1'b0; i_redirect_pc = '0;
        i_pred_jmp = 1'b0; i_pred_jmpaddr = '0;

        applyStimulus("reset0",      0,0,0,32'h0,         0,32'h0,    32'h8000_0000,0,2'b00,3'd0,0,0);
        applyStimulus("reset1",      0,0,0,32'h0,         0,32'h0,    32'h8000_0000,0,2'b00,3'd0,0,0);
        applyStimulus("boot2run",    1,0,0,32'h0,         0,32'h0,    32'h8000_0000,1,2'b11,3'd0,0,0);
        applyStimulus("seq1",        1,0,0,32'h0,         0,32'h0,    32'h8000_0008,1,2'b11,3'd0,0,0);
        applyStimulus("seq2",        1,0,0,32'h0,         0,32'h0,    32'h8000_0010,1,2'b11,3'd0,0,0);
        applyStimulus("redir_unal",  1,0,1,32'h8000_0104, 0,32'h0,    32'h8000_0104,1,2'b10,3'd1,0,0);
        applyStimulus("seq_partial", 1,0,0,32'h0,         0,32'h0,    32'h8000_0108,1,2'b11,3'd1,0,0);
        applyStimulus("stall_hold",  1,1,0,32'h0,         0,32'h0,    32'h8000_0108,1,2'b11,3'd1,0,0);
        applyStimulus("pred_jmp",    1,0,0,32'h0,         1,32'h4000, 32'h0000_4000,1,2'b11,3'd1,0,0);
        applyStimulus("redir_stall", 1,1,1,32'h200,       0,32'h0,    32'h0000_4000,0,2'b00,3'd2,1,0);
        applyStimulus("pend_over",   1,1,1,32'h300,       0,32'h0,    32'h0000_4000,0,2'b00,3'd3,1,0);
        applyStimulus("pend_pjign",  1,1,0,32'h0,         1,32'h9000, 32'h0000_4000,0,2'b00,3'd3,1,0);
        applyStimulus("pend_rel",    1,0,0,32'h0,         0,32'h0,    32'h0000_0300,1,2'b11,3'd3,0,0);
        applyStimulus("redir_v_pj",  1,0,1,32'h5000,      1,32'h4000, 32'h0000_5000,1,2'b11,3'd4,0,0);
        applyStimulus("pj_misal",    1,0,0,32'h0,         1,32'h600E, 32'h0000_600C,1,2'b10,3'd4,0,1);
        applyStimulus("seq_mis_clr", 1,0,0,32'h0,         0,32'h0,    32'h0000_6010,1,2'b11,3'd4,0,0);
        applyStimulus("redir_1002",  1,0,1,32'h1002,      0,32'h0,    32'h0000_1000,1,2'b11,3'd5,0,1);
        applyStimulus("seq_1008",    1,0,0,32'h0,         0,32'h0,    32'h0000_1008,1,2'b11,3'd5,0,0);
        applyStimulus("pend_again",  1,1,1,32'h2000,      0,32'h0,    32'h0000_1008,0,2'b00,3'd6,1,0);
        applyStimulus("pend_rel_rd", 1,0,1,32'h2006,      0,32'h0,    32'h0000_2004,1,2'b10,3'd7,0,1);
        applyStimulus("epoch_wrap",  1,0,1,32'h3000,      0,32'h0,    32'h0000_3000,1,2'b11,3'd0,0,0);
        applyStimulus("pend_pre_rs", 1,1,1,32'h7000,      0,32'h0,    32'h0000_3000,0,2'b00,3'd1,1,0);
        applyStimulus("reset_pend",  0,0,0,32'h0,         0,32'h0,    32'h8000_0000,0,2'b00,3'd0,0,0);
        applyStimulus("boot_redir",  1,1,1,32'h100,       1,32'h40,   32'h0000_0100,1,2'b11,3'd1,0,0);
        applyStimulus("redir_top",   1,0,1,32'hFFFF_FFF8, 0,32'h0,    32'hFFFF_FFF8,1,2'b11,3'd2,0,0);
        applyStimulus("pc_wrap",     1,0,0,32'h0,         0,32'h0,    32'h0000_0000,1,2'b11,3'd2,0,0);
        applyStimulus("stall_v_pj",  1,1,0,32'h0,         1,32'h40,   32'h0000_0000,1,2'b11,3'd2,0,0);
        applyStimulus("pend_misal",  1,1,1,32'h505,       0,32'h0,    32'h0000_0000,0,2'b00,3'd3,1,0);
        applyStimulus("rel_misal",   1,0,0,32'h0,         0,32'h0,    32'h0000_0504,1,2'b10,3'd3,0,1);
        applyStimulus("seq_508",     1,0,0,32'h0,         0,32'h0,    32'h0000_0508,1,2'b11,3'd3,0,0);

        @(negedge clk);
        i_redirect = 1'b0; i_pred_jmp = 1'b0; i_stall = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL drain: got %0d unchecked entries, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        done = 1'b1;
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #20000;
        if (!done) begin
            $display("[TB] FAIL watchdog: got timeout, want completion");
            $fatal(1, "[TB] watchdog expired");
        end
    end

endmodule
